// File: rtl/ro_store_pkg.sv
// Shared types and constants for the ring-oscillator count RAM readout path.
package ro_store_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        WAIT,
        SEND,
        FIN
    } rdo_state_t;

    localparam int         DEFAULT_DATA_W    = 32;
    localparam int         BYTES_PER_WORD    = DEFAULT_DATA_W / 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/word_serializer.sv
// Holds one RAM word and presents it MSB-first as bytes over a valid/ready handshake.
module word_serializer
    import ro_store_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_flush,
    output logic [7:0]        o_byte,
    output logic              o_valid,
    output logic              o_last_byte
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              w_accept;

    assign w_accept    = r_valid & i_ready;
    assign o_last_byte = (r_cnt == CNT_W'(BPW - 1));
    assign o_valid     = r_valid;
    assign o_byte      = r_valid ? r_shift[DATA_W-1 -: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_shift <= {r_shift[DATA_W-9:0], 8'h00};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (o_last_byte) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_readout_ctrl.sv
// Drains the count RAM to the UART: sync byte, then words 0..N-1 as 4 bytes MSB first.
module ram_readout_ctrl
    import ro_store_pkg::*;
#(
    parameter int         ADDR_W    = 11,
    parameter int         DATA_W    = DEFAULT_DATA_W,
    parameter int         RD_LAT    = 1,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    rdo_state_t      r_state;
    rdo_state_t      w_next;
    logic [ADDR_W:0] r_n;
    logic [ADDR_W:0] r_index;
    logic [ADDR_W:0] w_index_inc;
    logic [ADDR_W:0] w_clamped_n;
    logic [1:0]      r_lat_cnt;
    logic            r_done;
    logic            w_load;
    logic            w_flush;
    logic            w_ser_valid;
    logic            w_last_byte;
    logic [7:0]      w_ser_byte;

    assign w_index_inc = r_index + (ADDR_W+1)'(1);
    assign w_clamped_n = (word_count > DEPTH) ? DEPTH : word_count;

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (rd_data),
        .i_ready     (tx_ready),
        .i_flush     (w_flush),
        .o_byte      (w_ser_byte),
        .o_valid     (w_ser_valid),
        .o_last_byte (w_last_byte)
    );

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        w_next  = r_state;
        w_load  = 1'b0;
        w_flush = 1'b0;
        unique case (r_state)
            IDLE: if (start) w_next = HDR;
            HDR: begin
                if (tx_ready) begin
                    if (abort)           w_next = IDLE;
                    else if (r_n == '0)  w_next = FIN;
                    else                 w_next = RD;
                end
            end
            RD:   w_next = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (r_lat_cnt == 2'(RD_LAT - 1)) begin
                    w_load = 1'b1;
                    w_next = SEND;
                end
            end
            SEND: begin
                // An abort only takes effect once the byte on the wire is accepted.
                if (tx_ready) begin
                    if (abort) begin
                        w_flush = 1'b1;
                        w_next  = IDLE;
                    end else if (w_last_byte) begin
                        w_next = (w_index_inc == r_n) ? FIN : RD;
                    end
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_index   <= '0;
            r_lat_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIN) && !abort;
            if (r_state == IDLE && start) begin
                r_n     <= w_clamped_n;
                r_index <= '0;
            end else if (r_state == SEND && tx_ready && !abort && w_last_byte) begin
                r_index <= w_index_inc;
            end
            if (r_state == RD) begin
                r_lat_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign rd_en    = (r_state == RD);
    assign rd_addr  = r_index[ADDR_W-1:0];
    assign tx_valid = (r_state == HDR) | w_ser_valid;
    assign tx_data  = (r_state == HDR) ? SYNC_BYTE : w_ser_byte;

endmodule

// File: tb/tb_ram_readout_ctrl.sv
// Directed bench for ram_readout_ctrl: vector table plus abort, reset and read-latency sequences.
module tb_ram_readout_ctrl;
    import ro_store_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int wc;
        bit rnd;
        int restart_at;
        int exp_bytes;
        int exp_rd;
        int exp_last_addr;
        int exp_done_cyc;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tx_ready;
    logic [ADDR_W:0]   word_count = '0;
    logic              rd_en, tx_valid, busy, done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;

    logic              start_b = 1'b0;
    logic              abort_b = 1'b0;
    logic              ready_b = 1'b1;
    logic [ADDR_W:0]   wc_b = 12'd4;
    logic              rd_en2, tx_valid2, busy2, done2;
    logic              rd_en3, tx_valid3, busy3, done3;
    logic [ADDR_W-1:0] rd_addr2, rd_addr3;
    logic [DATA_W-1:0] rd_data2, rd_data3, s2, s3a, s3b;
    logic [7:0]        tx_data2, tx_data3;

    logic [DATA_W-1:0] mem [2048];

    int      n_cmp = 0;
    int      n_fail = 0;
    int      cyc_cnt = 0;
    int      start_cyc = 0, start_b_cyc = 0;
    bit      rand_mode = 1'b0;
    logic    ready_level = 1'b1;
    byte_q_t q_bytes, q2, q3;
    int      rd_cnt, addr_err, exp_addr, last_addr, done_cnt, done_cyc, stab_err;
    int      done2_cyc = -1, done3_cyc = -1;
    bit      stalled = 1'b0;
    logic [7:0] stalled_data = 8'h00;

    ram_readout_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .SYNC_BYTE(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));

    ram_readout_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .SYNC_BYTE(8'hA5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_b), .word_count(wc_b), .abort(abort_b),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(ready_b), .busy(busy2), .done(done2));

    ram_readout_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .SYNC_BYTE(8'hA5)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_b), .word_count(wc_b), .abort(abort_b),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3), .tx_data(tx_data3),
        .tx_valid(tx_valid3), .tx_ready(ready_b), .busy(busy3), .done(done3));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // RAM models return a poison word unless a read was issued exactly RD_LAT cycles earlier.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        s2       <= rd_en2 ? mem[rd_addr2] : 32'hDEAD_BEEF;
        rd_data2 <= s2;
        s3a      <= rd_en3 ? mem[rd_addr3] : 32'hDEAD_BEEF;
        s3b      <= s3a;
        rd_data3 <= s3b;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) q_bytes.push_back(tx_data);
        if (rd_en) begin
            if (rd_addr !== 11'(exp_addr)) addr_err++;
            exp_addr++;
            last_addr = int'(rd_addr);
            rd_cnt++;
        end
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc_cnt - start_cyc;
            done_cnt++;
        end
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && !(tx_valid && tx_data == stalled_data)) stab_err++;
            stalled      = tx_valid && !tx_ready;
            stalled_data = tx_data;
        end
        if (tx_valid2) q2.push_back(tx_data2);
        if (tx_valid3) q3.push_back(tx_data3);
        if (done2 && done2_cyc < 0) done2_cyc = cyc_cnt - start_b_cyc;
        if (done3 && done3_cyc < 0) done3_cyc = cyc_cnt - start_b_cyc;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        if (k == 0) return 8'hA5;
        w = 32'h1000_0000 + 32'((k - 1) / 4);
        return w[31 - 8 * ((k - 1) % 4) -: 8];
    endfunction

    task automatic check_stream(input string name, input byte_q_t q, input int n_exp);
        int bad = 0;
        check({name, "_len"}, 64'(q.size()), 64'(n_exp));
        for (int k = 0; k < q.size(); k++) begin
            if (q[k] !== exp_byte(k)) bad++;
        end
        check({name, "_bad_bytes"}, 64'(bad), 64'd0);
    endtask

    task automatic clear_mon();
        q_bytes.delete();
        rd_cnt    = 0;
        addr_err  = 0;
        exp_addr  = 0;
        last_addr = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        stab_err  = 0;
    endtask

    task automatic pulse_start(input int wc);
        @(posedge clk);
        #1;
        clear_mon();
        word_count = (ADDR_W+1)'(wc);
        start      = 1'b1;
        start_cyc  = cyc_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit got_done = 1'b0;
        rand_mode   = v.rnd;
        ready_level = 1'b1;
        pulse_start(v.wc);
        if (v.restart_at > 1) begin
            repeat (v.restart_at - 1) @(posedge clk);
            #1;
            start      = 1'b1;
            word_count = 12'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < 20000 && !got_done; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) got_done = 1'b1;
        end
        check({name, "_done_seen"}, 64'(got_done), 64'd1);
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check({name, "_idle"}, {busy, tx_valid, rd_en}, 64'd0);
        check_stream(name, q_bytes, v.exp_bytes);
        check({name, "_rd_cnt"}, 64'(rd_cnt), 64'(v.exp_rd));
        check({name, "_addr_seq"}, 64'(addr_err), 64'd0);
        check({name, "_stable"}, 64'(stab_err), 64'd0);
        if (v.exp_last_addr >= 0) check({name, "_last_addr"}, 64'(last_addr), 64'(v.exp_last_addr));
        if (v.exp_done_cyc >= 0) check({name, "_done_cyc"}, 64'(done_cyc), 64'(v.exp_done_cyc));
    endtask

    vec_t vecs[6];

    initial begin
        bit hit;
        vecs[0] = '{3,    0, 0, 13,   3,    2,    21};
        vecs[1] = '{0,    0, 0, 1,    0,    -1,   3};
        vecs[2] = '{4095, 0, 0, 8193, 2048, 2047, 12291};
        vecs[3] = '{16,   1, 0, 65,   16,   15,   -1};
        vecs[4] = '{1,    0, 0, 5,    1,    0,    9};
        vecs[5] = '{3,    0, 5, 13,   3,    2,    21};
        for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + 32'(i);
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, rd_en, tx_valid, tx_data, rd_addr}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_released_idle", {busy, done, rd_en, tx_valid, tx_data}, 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort while the second byte of word 5 is stalled.
        rand_mode   = 1'b0;
        ready_level = 1'b1;
        pulse_start(8);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (q_bytes.size() >= 22) hit = 1'b1;
        end
        ready_level = 1'b0;
        check("abort_reach_word5", 64'(hit), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("abort_stall_valid", 64'(tx_valid), 64'd1);
        check("abort_stall_data", 64'(tx_data), 64'h00);
        check("abort_stall_count", 64'(q_bytes.size()), 64'd22);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("abort_held", {busy, tx_valid}, 64'b11);
        ready_level = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_idle", {busy, tx_valid, rd_en}, 64'd0);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_rd_cnt", 64'(rd_cnt), 64'd6);
        check_stream("abort_stream", q_bytes, 23);
        abort = 1'b0;
        run_vec('{2, 0, 0, 9, 2, 1, 15}, "after_abort");

        // Asynchronous reset in the middle of SEND.
        pulse_start(3);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (q_bytes.size() >= 3) hit = 1'b1;
        end
        check("rst_pre_busy", {hit, busy, tx_valid}, 64'b111);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outs", {busy, done, rd_en, tx_valid, tx_data, rd_addr}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec('{2, 0, 0, 9, 2, 1, 15}, "after_rst");

        // Longer read latencies must produce the same stream for N = 4.
        @(posedge clk);
        #1;
        q2.delete();
        q3.delete();
        done2_cyc   = -1;
        done3_cyc   = -1;
        start_b     = 1'b1;
        start_b_cyc = cyc_cnt;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (done2_cyc >= 0 && done3_cyc >= 0) hit = 1'b1;
        end
        check("lat_done_seen", 64'(hit), 64'd1);
        check_stream("lat2", q2, 17);
        check_stream("lat3", q3, 17);
        check("lat2_done_cyc", 64'(done2_cyc), 64'd31);
        check("lat3_done_cyc", 64'(done3_cyc), 64'd35);
        check("lat_idle", {busy2, busy3}, 64'd0);
        check("bytes_per_word", 64'(BYTES_PER_WORD), 64'(DATA_W / 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
